// File: rtl/ami_channel_arbiter_pkg.sv
// Shared AMI request type and arbiter defaults for the per-channel scheduler.
package ami_channel_arbiter_pkg;

    localparam int AMI_ARB_MAX_BURST = 4;
    localparam int AMI_ARB_CNT_WIDTH = 32;

    localparam int AMI_ADDR_W = 48;
    localparam int AMI_DATA_W = 32;
    localparam int AMI_CH_W   = 2;

    typedef struct packed {
        logic                  valid;
        logic                  is_write;
        logic [AMI_ADDR_W-1:0] addr;
        logic [AMI_DATA_W-1:0] data;
        logic [AMI_CH_W-1:0]   channel;
    } AMIReq;

    // Index width that stays legal (>=1 bit) for a single-entry range.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set bit of eligible_i at or after start_i (wrapping).
module rr_priority_pick
    import ami_channel_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  pick_oh_o,
    output logic [IW-1:0] pick_idx_o,
    output logic          any_o
);

    always_comb begin
        int idx;
        idx        = 0;
        pick_idx_o = '0;
        any_o      = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(start_i) + k) % N;
            if (!any_o && eligible_i[idx]) begin
                any_o      = 1'b1;
                pick_idx_o = IW'(idx);
            end
        end
        pick_oh_o = any_o ? (N'(1) << pick_idx_o) : '0;
    end

endmodule

// File: rtl/ami_channel_arbiter.sv
// Per-channel AMI scheduler: round-robin with bounded same-requester bursts and a registered
// output slot that refills in the cycle it is drained.
module ami_channel_arbiter
    import ami_channel_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = AMI_ARB_MAX_BURST,
    parameter int CNT_WIDTH = AMI_ARB_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_en,
    input  AMIReq                req_in [NUM_REQ],
    output logic [NUM_REQ-1:0]   req_grant_out,
    output AMIReq                req_out,
    input  logic                 req_grant_in,
    output logic [CNT_WIDTH-1:0] grant_count,
    output logic                 busy
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int BW = idx_width(MAX_BURST);

    AMIReq                out_q, out_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        last_idx_q, last_idx_d;
    logic                 last_vld_q, last_vld_d;
    logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
    logic [CNT_WIDTH-1:0] grant_count_q, grant_count_d;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   rr_oh;
    logic [IW-1:0]        rr_idx;
    logic                 rr_any;
    logic                 load_ok;
    logic                 hold;
    logic                 grant;
    logic [IW-1:0]        winner;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_in[i].valid & req_en[i];
        end
    end

    rr_priority_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .eligible_i (eligible),
        .start_i    (rr_ptr_q),
        .pick_oh_o  (rr_oh),
        .pick_idx_o (rr_idx),
        .any_o      (rr_any)
    );

    // last_vld_q keeps the reset value of last_idx from counting as the start of a burst.
    always_comb begin
        load_ok = !out_q.valid || req_grant_in;
        hold    = last_vld_q && eligible[last_idx_q] && (int'(burst_cnt_q) < MAX_BURST - 1);
        grant   = reset_n && load_ok && (hold || rr_any);
        winner  = hold ? last_idx_q : rr_idx;

        req_grant_out = '0;
        if (grant) begin
            req_grant_out = hold ? (NUM_REQ'(1) << last_idx_q) : rr_oh;
        end

        out_d         = out_q;
        rr_ptr_d      = rr_ptr_q;
        last_idx_d    = last_idx_q;
        last_vld_d    = last_vld_q;
        burst_cnt_d   = burst_cnt_q;
        grant_count_d = grant_count_q;

        if (grant) begin
            out_d       = req_in[winner];
            out_d.valid = 1'b1;
            last_idx_d  = winner;
            last_vld_d  = 1'b1;
            burst_cnt_d = hold ? burst_cnt_q + BW'(1) : '0;
            rr_ptr_d    = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + IW'(1);
        end else if (req_grant_in) begin
            out_d.valid = 1'b0;
        end

        if (out_q.valid && req_grant_in) begin
            grant_count_d = grant_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q         <= '0;
            rr_ptr_q      <= '0;
            last_idx_q    <= '0;
            last_vld_q    <= 1'b0;
            burst_cnt_q   <= '0;
            grant_count_q <= '0;
        end else begin
            out_q         <= out_d;
            rr_ptr_q      <= rr_ptr_d;
            last_idx_q    <= last_idx_d;
            last_vld_q    <= last_vld_d;
            burst_cnt_q   <= burst_cnt_d;
            grant_count_q <= grant_count_d;
        end
    end

    assign req_out     = out_q;
    assign grant_count = grant_count_q;
    assign busy        = out_q.valid | (|eligible);

endmodule

// File: tb/tb_ami_channel_arbiter.sv
// Bench for ami_channel_arbiter: two instances (MAX_BURST=4 and 1) on shared inputs, checked
// against a rule-level reference model, a vector table and directed corner-case sequences.
module tb_ami_channel_arbiter;
    import ami_channel_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [3:0]  req_en;
    AMIReq       req_in [4];
    logic        req_grant_in;

    logic [3:0]  gnt  [2];
    AMIReq       rout [2];
    logic [31:0] gcnt [2];
    logic        bsy  [2];

    ami_channel_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .req_en(req_en), .req_in(req_in),
        .req_grant_out(gnt[0]), .req_out(rout[0]), .req_grant_in(req_grant_in),
        .grant_count(gcnt[0]), .busy(bsy[0]));

    ami_channel_arbiter #(.NUM_REQ(4), .MAX_BURST(1), .CNT_WIDTH(32)) dut1 (
        .clk(clk), .reset_n(reset_n), .req_en(req_en), .req_in(req_in),
        .req_grant_out(gnt[1]), .req_out(rout[1]), .req_grant_in(req_grant_in),
        .grant_count(gcnt[1]), .busy(bsy[1]));

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state, one set per instance.
    AMIReq       m_out   [2];
    int          m_ptr   [2];
    int          m_last  [2];
    logic        m_haslast [2];
    int          m_burst [2];
    logic [31:0] m_cnt   [2];

    int          w_pend  [2];
    logic        h_pend  [2];
    AMIReq       pay_pend[2];
    logic        rst_pend;
    logic        gin_pend;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic int model_pick(input int k, output logic hold);
        int         maxb;
        logic [3:0] elig;
        maxb = (k == 0) ? 4 : 1;
        hold = 1'b0;
        for (int i = 0; i < 4; i++) elig[i] = req_in[i].valid & req_en[i];
        if (!reset_n || elig == 4'b0 || (m_out[k].valid && !req_grant_in)) return -1;
        if (m_haslast[k] && elig[m_last[k]] && m_burst[k] < maxb - 1) begin
            hold = 1'b1;
            return m_last[k];
        end
        for (int j = 0; j < 4; j++) begin
            if (elig[(m_ptr[k] + j) % 4]) return (m_ptr[k] + j) % 4;
        end
        return -1;
    endfunction

    task automatic eval_half();
        logic [3:0] exp_g;
        logic       any_e;
        @(negedge clk);
        any_e = |(req_en & {req_in[3].valid, req_in[2].valid, req_in[1].valid, req_in[0].valid});
        for (int k = 0; k < 2; k++) begin
            w_pend[k]   = model_pick(k, h_pend[k]);
            exp_g       = (w_pend[k] >= 0) ? (4'b0001 << w_pend[k]) : 4'b0000;
            pay_pend[k] = (w_pend[k] >= 0) ? req_in[w_pend[k]] : '0;
            chk($sformatf("grant%0d", k), 128'(gnt[k]), 128'(exp_g));
            chk($sformatf("busy%0d", k), 128'(bsy[k]), 128'(m_out[k].valid | any_e));
        end
        rst_pend = reset_n;
        gin_pend = req_grant_in;
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_pend) begin
                m_out[k] = '0; m_ptr[k] = 0; m_last[k] = 0; m_haslast[k] = 1'b0;
                m_burst[k] = 0; m_cnt[k] = '0;
            end else begin
                if (m_out[k].valid && gin_pend) m_cnt[k] = m_cnt[k] + 32'd1;
                if (w_pend[k] >= 0) begin
                    m_out[k]       = pay_pend[k];
                    m_out[k].valid = 1'b1;
                    m_burst[k]     = h_pend[k] ? m_burst[k] + 1 : 0;
                    m_last[k]      = w_pend[k];
                    m_haslast[k]   = 1'b1;
                    m_ptr[k]       = (w_pend[k] + 1) % 4;
                end else if (gin_pend) begin
                    m_out[k].valid = 1'b0;
                end
            end
            chk($sformatf("req_out%0d", k), 128'(rout[k]), 128'(m_out[k]));
            chk($sformatf("grant_count%0d", k), 128'(gcnt[k]), 128'(m_cnt[k]));
        end
    endtask

    task automatic cycle();
        eval_half();
        commit();
    endtask

    task automatic set_in(input logic [3:0] vld, input logic [3:0] en, input logic gin);
        for (int i = 0; i < 4; i++) begin
            req_in[i].valid    = vld[i];
            req_in[i].is_write = 1'($urandom);
            req_in[i].addr     = {16'(i), 32'($urandom)};
            req_in[i].data     = 32'($urandom);
            req_in[i].channel  = 2'($urandom);
        end
        req_en       = en;
        req_grant_in = gin;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_in(4'b0000, 4'b1111, 1'b0);
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] vld;
        logic [3:0] en;
        logic [3:0] g0;
        logic [3:0] g1;
    } vec_t;

    vec_t  tbl [9];
    AMIReq snap;

    initial begin
        tbl[0] = '{4'b1111, 4'b1111, 4'b0001, 4'b0001};
        tbl[1] = '{4'b1111, 4'b1111, 4'b0001, 4'b0010};
        tbl[2] = '{4'b1111, 4'b1111, 4'b0001, 4'b0100};
        tbl[3] = '{4'b1111, 4'b1111, 4'b0001, 4'b1000};
        tbl[4] = '{4'b1111, 4'b1111, 4'b0010, 4'b0001};
        tbl[5] = '{4'b1111, 4'b1011, 4'b0010, 4'b0010};
        tbl[6] = '{4'b1111, 4'b1011, 4'b0010, 4'b1000};
        tbl[7] = '{4'b1111, 4'b1011, 4'b0010, 4'b0001};
        tbl[8] = '{4'b1111, 4'b1011, 4'b1000, 4'b0010};

        for (int k = 0; k < 2; k++) begin
            m_out[k] = '0; m_ptr[k] = 0; m_last[k] = 0; m_haslast[k] = 1'b0;
            m_burst[k] = 0; m_cnt[k] = '0;
        end
        #2;
        do_reset();

        // Idle after reset.
        set_in(4'b0000, 4'b1111, 1'b0);
        eval_half();
        chk("idle_grant", 128'(gnt[0]), 128'(4'b0000));
        commit();
        chk("idle_valid", 128'(rout[0].valid), 128'(1'b0));
        chk("idle_count", 128'(gcnt[0]), 128'(32'd0));

        // Single requester: grant in cycle 0, data in cycle 1, count in cycle 2.
        set_in(4'b0010, 4'b1111, 1'b1);
        req_in[1].addr = 48'h40;
        eval_half();
        chk("single_grant", 128'(gnt[0]), 128'(4'b0010));
        commit();
        chk("single_addr", 128'({rout[0].valid, rout[0].addr}), 128'({1'b1, 48'h40}));
        set_in(4'b0000, 4'b1111, 1'b1);
        cycle();
        chk("single_count", 128'(gcnt[0]), 128'(32'd1));

        // Burst / round-robin order table.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].vld, tbl[i].en, 1'b1);
            eval_half();
            chk($sformatf("tbl%0d_g0", i), 128'(gnt[0]), 128'(tbl[i].g0));
            chk($sformatf("tbl%0d_g1", i), 128'(gnt[1]), 128'(tbl[i].g1));
            commit();
        end

        // Downstream stall: slot held, no grants; release grants in the same cycle.
        set_in(4'b1111, 4'b1111, 1'b1);
        cycle();
        snap = m_out[0];
        for (int i = 0; i < 5; i++) begin
            set_in(4'b1111, 4'b1111, 1'b0);
            eval_half();
            chk("stall_grant", 128'(gnt[0]), 128'(4'b0000));
            commit();
            chk("stall_hold", 128'(rout[0]), 128'(snap));
        end
        set_in(4'b1111, 4'b1111, 1'b1);
        eval_half();
        chk("release_bypass", 128'(|gnt[0]), 128'(1'b1));
        commit();
        cycle();

        // Reset in the middle of a burst.
        do_reset();
        set_in(4'b1111, 4'b1111, 1'b1);
        cycle(); cycle(); cycle();
        reset_n = 1'b0;
        eval_half();
        chk("rst_grant", 128'(gnt[0]), 128'(4'b0000));
        commit();
        chk("rst_valid", 128'(rout[0].valid), 128'(1'b0));
        chk("rst_count", 128'(gcnt[0]), 128'(32'd0));
        reset_n = 1'b1;
        set_in(4'b1100, 4'b1111, 1'b1);
        eval_half();
        chk("post_rst_g0", 128'(gnt[0]), 128'(4'b0100));
        chk("post_rst_g1", 128'(gnt[1]), 128'(4'b0100));
        commit();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            set_in(4'($urandom), 4'($urandom) | 4'($urandom), $urandom_range(0, 3) != 0);
            cycle();
        end
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
